mac_accumulator: RTL and testbench

Downstream consumer for the sequential multipliers (`radix_2_booth_multiplier` and relatives).
- Watches the multiplier's `ready` and captures each new signed product.
- Sums a programmed number of products into a wider signed accumulator.
- Pulses a one-cycle valid when the block sum is complete.
- Together with a multiplier, forms the team's multiply-accumulate datapath.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/rise_detect.sv | 21 ++
 rtl/mac_accumulator.sv | 127 ++++++++++++
 tb/tb_mac_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the multiply-accumulate datapath.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  // Largest positive two's-complement value representable in w bits.
  function automatic logic signed [63:0] signed_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value representable in w bits.
  function automatic logic signed [63:0] signed_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector; a level held high reports a single event.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q_reg <= 1'b0;
    end else begin
      sig_q_reg <= sig;
    end
  end

  assign rise = sig & ~sig_q_reg;

endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed number of signed multiplier products into a wide accumulator.
// Define MAC_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*WIDTH-1:0]     prod,
  input  logic                   prod_ready,
  input  logic                   blk_start,
  input  logic [COUNT_WIDTH-1:0] blk_len,
  input  logic                   clear,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   acc_valid,
  output logic                   busy,
  output logic                   overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = COUNT_WIDTH + 1;

`ifdef MAC_ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(signed_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(signed_min(ACC_WIDTH));
`endif

  mac_state_t           state_reg, state_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [RW-1:0]        remaining_reg;
  logic [RW-1:0]        len_load;
  logic                 overflow_reg;
  logic                 prod_event;
  logic                 take;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 sum_ovf;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (prod_ready),
    .rise (prod_event)
  );

  // A restart or abort in the same cycle swallows the product.
  assign take = (state_reg == ACCUM) && prod_event && !blk_start && !clear;

  assign len_load = (blk_len == '0) ? {1'b1, {COUNT_WIDTH{1'b0}}} : {1'b0, blk_len};

  assign sum_ext = {acc_reg[ACC_WIDTH-1], acc_reg}
                 + {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod};
  assign sum_ovf = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];

  always_comb begin
`ifdef MAC_ACC_SATURATE_EN
    // The extra top bit carries the sign of the true sum.
    if (sum_ovf) begin
      acc_next = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_ext[ACC_WIDTH-1:0];
    end
`else
    acc_next = sum_ext[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else if (blk_start) begin
      state_next = ACCUM;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        ACCUM:   if (take && remaining_reg == RW'(1)) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    acc_valid = 1'b0;
    case (state_reg)
      ACCUM:   busy = 1'b1;
      DONE:    acc_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg       <= '0;
      remaining_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (clear) begin
      acc_reg       <= '0;
      remaining_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (blk_start) begin
      acc_reg       <= '0;
      remaining_reg <= len_load;
      overflow_reg  <= 1'b0;
    end else if (take) begin
      acc_reg       <= acc_next;
      remaining_reg <= remaining_reg - RW'(1);
      overflow_reg  <= overflow_reg | sum_ovf;
    end
  end

  assign acc_out  = acc_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: a 24-bit/4-bit-count instance and a 16-bit/2-bit-count instance share stimulus.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] prod;
  logic        prod_ready;
  logic        blk_start;
  logic        clear;
  logic [3:0]  blk_len_a;
  logic [1:0]  blk_len_b;

  logic [23:0] acc_a;
  logic        valid_a, busy_a, ovf_a;
  logic [15:0] acc_b;
  logic        valid_b, busy_b, ovf_b;

  int     n_pass  = 0;
  int     n_total = 0;
  longint exp_a, exp_b;
  bit     eovf_a, eovf_b;
  int     cnt_a, cnt_b;
  bit     chk_b;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .COUNT_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_ready(prod_ready),
    .blk_start(blk_start), .blk_len(blk_len_a), .clear(clear),
    .acc_out(acc_a), .acc_valid(valid_a), .busy(busy_a), .overflow(ovf_a)
  );

  mac_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .COUNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_ready(prod_ready),
    .blk_start(blk_start), .blk_len(blk_len_b), .clear(clear),
    .acc_out(acc_b), .acc_valid(valid_b), .busy(busy_b), .overflow(ovf_b)
  );

  // Reference: add one product to a w-bit signed accumulator, reporting overflow.
  function automatic longint model_add(input longint acc, input longint p, input int w,
                                       output bit o);
    longint m, mx, mn, s;
    m  = longint'(1) <<< w;
    mx = (m >>> 1) - 1;
    mn = -(m >>> 1);
    s  = acc + p;
    o  = (s > mx) || (s < mn);
`ifdef MAC_ACC_SATURATE_EN
    if (s > mx) s = mx;
    else if (s < mn) s = mn;
`else
    s = s & (m - 1);
    if (s > mx) s = s - m;
`endif
    return s;
  endfunction

  function automatic longint rand_prod();
    logic signed [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    return longint'(a) * longint'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic check_outputs(input string tag, input bit va, input bit vb);
    chk({tag, "_acc_a"},   $signed(acc_a), exp_a);
    chk({tag, "_ovf_a"},   ovf_a, eovf_a);
    chk({tag, "_valid_a"}, valid_a, va);
    chk({tag, "_busy_a"},  busy_a, cnt_a > 0);
    if (chk_b) begin
      chk({tag, "_acc_b"},   $signed(acc_b), exp_b);
      chk({tag, "_ovf_b"},   ovf_b, eovf_b);
      chk({tag, "_valid_b"}, valid_b, vb);
      chk({tag, "_busy_b"},  busy_b, cnt_b > 0);
    end
  endtask

  // Start an n-product block; with evt set, a ready rise coincides and must be dropped.
  task automatic start_block(input int n, input bit evt);
    blk_start  = 1'b1;
    blk_len_a  = 4'(n);
    blk_len_b  = 2'(n);
    prod_ready = evt;
    if (evt) prod = 16'(rand_prod());
    step();
    blk_start = 1'b0;
    chk_b  = (n <= 4);
    exp_a  = 0; exp_b  = 0;
    eovf_a = 0; eovf_b = 0;
    cnt_a  = n; cnt_b  = n;
    check_outputs("start", 1'b0, 1'b0);
    $display("start block n=%0d coincident_event=%0d", n, evt);
    if (evt) begin
      prod_ready = 1'b0;
      step();
      check_outputs("start_gap", 1'b0, 1'b0);
    end
  endtask

  task automatic do_event(input longint p, input int hold, input int gap);
    bit o, last_a, last_b;
    prod       = 16'(p);
    prod_ready = 1'b1;
    step();
    last_a = 1'b0;
    last_b = 1'b0;
    if (cnt_a > 0) begin
      exp_a  = model_add(exp_a, p, 24, o);
      eovf_a = eovf_a | o;
      cnt_a--;
      last_a = (cnt_a == 0);
    end
    if (chk_b && cnt_b > 0) begin
      exp_b  = model_add(exp_b, p, 16, o);
      eovf_b = eovf_b | o;
      cnt_b--;
      last_b = (cnt_b == 0);
    end
    check_outputs("event", last_a, last_b);
    $display("event prod=%0d acc_a=%0d acc_b=%0d valid_a=%0d valid_b=%0d",
             p, $signed(acc_a), $signed(acc_b), valid_a, valid_b);
    for (int i = 0; i < hold; i++) begin
      prod = 16'($urandom);
      step();
      check_outputs("hold", 1'b0, 1'b0);
    end
    if (gap > 0) begin
      prod_ready = 1'b0;
      for (int i = 0; i < gap; i++) begin
        step();
        check_outputs("gap", 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expected_finish_by=2000000 observed_time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; prod = '0; prod_ready = 1'b0; blk_start = 1'b0; clear = 1'b0;
    blk_len_a = '0; blk_len_b = '0;
    exp_a = 0; exp_b = 0; eovf_a = 0; eovf_b = 0; cnt_a = 0; cnt_b = 0; chk_b = 1'b1;

    @(negedge clk);
    check_outputs("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic sum.
    start_block(3, 1'b0);
    do_event(100, 0, 1);
    do_event(-50, 0, 1);
    do_event(7, 0, 1);
    chk("basic_sum_a", $signed(acc_a), 57);

    // Ready held high ten cycles counts once.
    start_block(2, 1'b0);
    do_event(25, 9, 1);
    chk("held_acc_a", $signed(acc_a), 25);
    do_event(5, 0, 2);

    // Overflow on the 16-bit instance.
    start_block(3, 1'b0);
    do_event(16129, 0, 1);
    do_event(16129, 0, 1);
    do_event(16129, 0, 1);
    chk("ovf_flag_b", ovf_b, 1'b1);
`ifdef MAC_ACC_SATURATE_EN
    chk("ovf_sum_b", $signed(acc_b), 32767);
`else
    chk("ovf_sum_b", $signed(acc_b), -17149);
`endif
    chk("no_ovf_sum_a", $signed(acc_a), 48387);

    // Length field 0 means the full count (4 on the 2-bit instance).
    start_block(4, 1'b0);
    for (int i = 0; i < 4; i++) do_event(1, 0, 1);
    chk("len0_sum_b", $signed(acc_b), 4);

    // Length field 0 means 16 on the 4-bit instance; restart right in the DONE cycle.
    start_block(16, 1'b0);
    for (int i = 0; i < 15; i++) do_event(rand_prod(), 0, 1);
    do_event(rand_prod(), 0, 0);
    start_block(2, 1'b0);
    do_event(300, 0, 1);
    do_event(-1000, 0, 1);

    // Clear and start together mid-block: clear wins, later events ignored.
    start_block(3, 1'b0);
    do_event(11, 0, 1);
    do_event(22, 0, 1);
    clear = 1'b1; blk_start = 1'b1; blk_len_a = 4'd3; blk_len_b = 2'd3;
    prod_ready = 1'b1; prod = 16'd99;
    step();
    clear = 1'b0; blk_start = 1'b0;
    exp_a = 0; exp_b = 0; eovf_a = 0; eovf_b = 0; cnt_a = 0; cnt_b = 0;
    check_outputs("clear", 1'b0, 1'b0);
    prod_ready = 1'b0;
    step();
    do_event(55, 0, 1);
    do_event(66, 2, 1);

    // Restart mid-block with a coincident event that must be discarded.
    start_block(3, 1'b0);
    do_event(40, 0, 1);
    start_block(2, 1'b1);
    do_event(8, 1, 1);
    do_event(9, 0, 1);

    // Reset mid-block: outputs clear at once and the block never completes.
    start_block(3, 1'b0);
    do_event(13, 0, 1);
    do_event(14, 0, 1);
    rst_n = 1'b0;
    #1;
    exp_a = 0; exp_b = 0; eovf_a = 0; eovf_b = 0; cnt_a = 0; cnt_b = 0;
    check_outputs("async_rst", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    do_event(15, 0, 2);

    // Randomised blocks.
    for (int blk = 0; blk < 24; blk++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 16)) : int'($urandom_range(1, 4));
      start_block(n, $urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
        int gap;
        gap = (i == n - 1 && $urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
        do_event(rand_prod(), int'($urandom_range(0, 3)), gap);
      end
    end
    prod_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
